// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, derived-timing helpers and colours
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel clock derived from 50 MHz
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_PULSE = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_VID   = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_PULSE = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_VID   = 480;
  localparam int DEF_V_FRONT = 10;

  // RRR_GGG_BB colours used by the bit generator
  localparam logic [7:0] RGB_BLACK  = 8'b000_000_00;
  localparam logic [7:0] RGB_WHITE  = 8'b111_111_11;
  localparam logic [7:0] RGB_RED    = 8'b111_000_00;
  localparam logic [7:0] RGB_GREEN  = 8'b000_111_00;
  localparam logic [7:0] RGB_BLUE   = 8'b000_000_11;
  localparam logic [7:0] RGB_YELLOW = 8'b111_111_00;

  function automatic int axis_total(input int pulse, input int back, input int vid,
                                    input int front);
    return pulse + back + vid + front;
  endfunction

  function automatic int axis_act0(input int pulse, input int back);
    return pulse + back;
  endfunction

  // Constant-coefficient multiply unrolled into shifted adds
  function automatic logic [11:0] mul_const12(input logic [11:0] a, input int k);
    logic [11:0] acc;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      if (k[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: sync, back porch, active, front porch
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int PULSE = DEF_H_PULSE,
  parameter int BACK  = DEF_H_BACK,
  parameter int VID   = DEF_H_VID,
  parameter int FRONT = DEF_H_FRONT,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          i_en,
  output logic [CW-1:0] o_next,
  output logic          o_wrap,
  output logic          o_sync_next,
  output logic          o_active_next
);

  localparam int TOTAL = axis_total(PULSE, BACK, VID, FRONT);
  localparam int ACT0  = axis_act0(PULSE, BACK);
  localparam logic [CW-1:0] C_LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] C_PULSE  = CW'(PULSE);
  localparam logic [CW-1:0] C_ACT_LO = CW'(ACT0);
  localparam logic [CW-1:0] C_ACT_HI = CW'(ACT0 + VID);

  logic [CW-1:0] r_cnt;

  // Status is exported for the value the counter is about to take
  assign o_wrap        = (r_cnt == C_LAST);
  assign o_next        = !i_en ? r_cnt : (o_wrap ? '0 : r_cnt + CW'(1));
  assign o_sync_next   = (o_next < C_PULSE);
  assign o_active_next = (o_next >= C_ACT_LO) && (o_next < C_ACT_HI);

  always_ff @(posedge clk) begin
    if (!clear) r_cnt <= '0;
    else        r_cnt <= o_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing with tile coordinates and glyph prefetch address
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int H_PULSE         = DEF_H_PULSE,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int H_VID           = DEF_H_VID,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int V_PULSE         = DEF_V_PULSE,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int V_VID           = DEF_V_VID,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int TILE_BITS       = 4,
  parameter int FETCH_LEAD      = 2,
  parameter int CW              = 10
) (
  input  logic                    clk,
  input  logic                    clear,
  output logic                    pix_tick,
  output logic                    hSync,
  output logic                    vSync,
  output logic                    bright,
  output logic [CW-1:0]           x,
  output logic [CW-1:0]           y,
  output logic [CW-TILE_BITS-1:0] tile_col,
  output logic [CW-TILE_BITS-1:0] tile_row,
  output logic [TILE_BITS-1:0]    tile_px,
  output logic [TILE_BITS-1:0]    tile_py,
  output logic [11:0]             fetch_addr,
  output logic                    fetch_valid,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int H_ACT0 = axis_act0(H_PULSE, H_BACK);
  localparam int V_ACT0 = axis_act0(V_PULSE, V_BACK);
  localparam int COLS   = H_VID >> TILE_BITS;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          SYNC_ON    = (SYNC_ACTIVE_LOW == 0);
  localparam logic [CW-1:0] C_H_ACT0   = CW'(H_ACT0);
  localparam logic [CW-1:0] C_V_ACT0   = CW'(V_ACT0);
  localparam logic [CW:0]   C_LEAD     = (CW+1)'(FETCH_LEAD);
  localparam logic [CW:0]   C_HF_LO    = (CW+1)'(H_ACT0);
  localparam logic [CW:0]   C_HF_HI    = (CW+1)'(H_ACT0 + H_VID);

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic          w_v_en;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_bright;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic [CW:0]   w_hf;
  logic [CW:0]   w_hf_rel;
  logic [CW-1:0] w_v_rel;
  logic          w_fetch_valid;
  logic [11:0]   w_fetch_addr;

  assign w_tick = (r_div == C_DIV_LAST);
  assign w_v_en = w_tick & w_h_wrap;

  vga_axis_counter #(
    .PULSE(H_PULSE), .BACK(H_BACK), .VID(H_VID), .FRONT(H_FRONT), .CW(CW)
  ) u_h (
    .clk(clk), .clear(clear), .i_en(w_tick),
    .o_next(w_h_next), .o_wrap(w_h_wrap), .o_sync_next(w_h_sync), .o_active_next(w_h_act)
  );

  vga_axis_counter #(
    .PULSE(V_PULSE), .BACK(V_BACK), .VID(V_VID), .FRONT(V_FRONT), .CW(CW)
  ) u_v (
    .clk(clk), .clear(clear), .i_en(w_v_en),
    .o_next(w_v_next), .o_wrap(w_v_wrap), .o_sync_next(w_v_sync), .o_active_next(w_v_act)
  );

  assign w_bright = w_h_act & w_v_act;
  assign w_x      = w_bright ? (w_h_next - C_H_ACT0) : '0;
  assign w_y      = w_bright ? (w_v_next - C_V_ACT0) : '0;

  // Lookahead stays on the current line; past the active span it is simply invalid
  assign w_hf          = {1'b0, w_h_next} + C_LEAD;
  assign w_hf_rel      = w_hf - C_HF_LO;
  assign w_v_rel       = w_v_next - C_V_ACT0;
  assign w_fetch_valid = (w_hf >= C_HF_LO) && (w_hf < C_HF_HI) && w_v_act;
  assign w_fetch_addr  = w_fetch_valid
                         ? (mul_const12(12'(w_v_rel >> TILE_BITS), COLS) + 12'(w_hf_rel >> TILE_BITS))
                         : '0;

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_div       <= '0;
      pix_tick    <= 1'b0;
      hSync       <= SYNC_ON;
      vSync       <= SYNC_ON;
      bright      <= 1'b0;
      x           <= '0;
      y           <= '0;
      tile_col    <= '0;
      tile_row    <= '0;
      tile_px     <= '0;
      tile_py     <= '0;
      fetch_valid <= 1'b0;
      fetch_addr  <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_div       <= w_tick ? '0 : r_div + DW'(1);
      pix_tick    <= w_tick;
      hSync       <= w_h_sync ? SYNC_ON : ~SYNC_ON;
      vSync       <= w_v_sync ? SYNC_ON : ~SYNC_ON;
      bright      <= w_bright;
      x           <= w_x;
      y           <= w_y;
      tile_col    <= w_x[CW-1:TILE_BITS];
      tile_row    <= w_y[CW-1:TILE_BITS];
      tile_px     <= w_x[TILE_BITS-1:0];
      tile_py     <= w_y[TILE_BITS-1:0];
      fetch_valid <= w_fetch_valid;
      fetch_addr  <= w_fetch_addr;
      line_start  <= w_v_en;
      frame_start <= w_v_en & w_v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: default, CLK_DIV=1/active-high and small-frame instances
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear_a, clear_b, clear_c;

  logic       a_pix, a_hs, a_vs, a_br, a_fv, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [5:0] a_tc, a_tr;
  logic [3:0] a_px, a_py;
  logic [11:0] a_fa;

  logic       b_pix, b_hs, b_vs, b_br, b_fv, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [5:0] b_tc, b_tr;
  logic [3:0] b_px, b_py;
  logic [11:0] b_fa;

  logic       c_pix, c_hs, c_vs, c_br, c_fv, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_tc, c_tr;
  logic [1:0] c_px, c_py;
  logic [11:0] c_fa;

  vga_timing_gen u_a (
    .clk(clk), .clear(clear_a), .pix_tick(a_pix), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
    .x(a_x), .y(a_y), .tile_col(a_tc), .tile_row(a_tr), .tile_px(a_px), .tile_py(a_py),
    .fetch_addr(a_fa), .fetch_valid(a_fv), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_ACTIVE_LOW(0)) u_b (
    .clk(clk), .clear(clear_b), .pix_tick(b_pix), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
    .x(b_x), .y(b_y), .tile_col(b_tc), .tile_row(b_tr), .tile_px(b_px), .tile_py(b_py),
    .fetch_addr(b_fa), .fetch_valid(b_fv), .line_start(b_ls), .frame_start(b_fs)
  );

  // 41 x 15 raster: H 4/3/32/2, V 2/3/8/2, 4x4 tiles, 8 tile columns
  vga_timing_gen #(
    .CLK_DIV(2), .H_PULSE(4), .H_BACK(3), .H_VID(32), .H_FRONT(2),
    .V_PULSE(2), .V_BACK(3), .V_VID(8), .V_FRONT(2),
    .SYNC_ACTIVE_LOW(1), .TILE_BITS(2), .FETCH_LEAD(2), .CW(10)
  ) u_c (
    .clk(clk), .clear(clear_c), .pix_tick(c_pix), .hSync(c_hs), .vSync(c_vs), .bright(c_br),
    .x(c_x), .y(c_y), .tile_col(c_tc), .tile_row(c_tr), .tile_px(c_px), .tile_py(c_py),
    .fetch_addr(c_fa), .fetch_valid(c_fv), .line_start(c_ls), .frame_start(c_fs)
  );

  typedef struct {
    int h; int v;
    int hs; int vs; int br; int x; int y;
    int tc; int tr; int px; int py; int fv; int fa; int ls;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int c_mm = 0;
  int c_first = -1;

  task automatic c_model(input int k);
    int p, h, v, hf, tk, br, ex, ey, fv, fa, ls, fs;
    logic ok;
    p  = k / 2;
    tk = (k % 2 == 0) ? 1 : 0;
    h  = p % 41;
    v  = (p / 41) % 15;
    br = (h >= 7 && h < 39 && v >= 5 && v < 13) ? 1 : 0;
    ex = br ? h - 7 : 0;
    ey = br ? v - 5 : 0;
    hf = h + 2;
    fv = (hf >= 7 && hf < 39 && v >= 5 && v < 13) ? 1 : 0;
    fa = fv ? ((v - 5) / 4) * 8 + (hf - 7) / 4 : 0;
    ls = (tk == 1 && h == 0) ? 1 : 0;
    fs = (ls == 1 && v == 0) ? 1 : 0;
    ok = 1'b1;
    ok &= (int'(c_pix) == tk);
    ok &= (int'(c_hs) == ((h < 4) ? 0 : 1));
    ok &= (int'(c_vs) == ((v < 2) ? 0 : 1));
    ok &= (int'(c_br) == br);
    ok &= (int'(c_x) == ex) && (int'(c_y) == ey);
    ok &= (int'(c_tc) == ex / 4) && (int'(c_tr) == ey / 4);
    ok &= (int'(c_px) == ex % 4) && (int'(c_py) == ey % 4);
    ok &= (int'(c_fv) == fv) && (int'(c_fa) == fa);
    ok &= (int'(c_ls) == ls) && (int'(c_fs) == fs);
    if (!ok) begin
      c_mm++;
      if (c_first < 0) c_first = k;
    end
  endtask

  int ls_cnt, fs_cnt, ls1, ls2, hs_cnt, br_cnt, pix_lo, pos, nb;
  int fs1, fs2, br_rise, br_ticks, vs_low;
  logic prev_br;

  initial begin
    vecs[0]  = '{1,   0,  1, 1, 0, 0,   0,  0,  0, 0,  0, 0, 0,  0};
    vecs[1]  = '{95,  0,  1, 1, 0, 0,   0,  0,  0, 0,  0, 0, 0,  0};
    vecs[2]  = '{96,  1,  0, 1, 0, 0,   0,  0,  0, 0,  0, 0, 0,  0};
    vecs[3]  = '{0,   2,  1, 0, 0, 0,   0,  0,  0, 0,  0, 0, 0,  1};
    vecs[4]  = '{142, 35, 0, 0, 0, 0,   0,  0,  0, 0,  0, 1, 0,  0};
    vecs[5]  = '{144, 35, 0, 0, 1, 0,   0,  0,  0, 0,  0, 1, 0,  0};
    vecs[6]  = '{781, 35, 0, 0, 1, 637, 0,  39, 0, 13, 0, 1, 39, 0};
    vecs[7]  = '{783, 35, 0, 0, 1, 639, 0,  39, 0, 15, 0, 0, 0,  0};
    vecs[8]  = '{784, 35, 0, 0, 0, 0,   0,  0,  0, 0,  0, 0, 0,  0};
    vecs[9]  = '{0,   36, 1, 0, 0, 0,   0,  0,  0, 0,  0, 0, 0,  1};
    vecs[10] = '{782, 36, 0, 0, 1, 638, 1,  39, 0, 14, 1, 0, 0,  0};
    vecs[11] = '{158, 67, 0, 0, 1, 14,  32, 0,  2, 14, 0, 1, 81, 0};
    vecs[12] = '{160, 67, 0, 0, 1, 16,  32, 1,  2, 0,  0, 1, 81, 0};
    vecs[13] = '{300, 67, 0, 0, 1, 156, 32, 9,  2, 12, 0, 1, 89, 0};

    clear_a = 1'b0;
    clear_b = 1'b0;
    clear_c = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_a_hsync", int'(a_hs), 0);
    check("rst_a_vsync", int'(a_vs), 0);
    check("rst_a_bright", int'(a_br), 0);
    check("rst_a_x", int'(a_x), 0);
    check("rst_a_y", int'(a_y), 0);
    check("rst_a_fetch_addr", int'(a_fa), 0);
    check("rst_a_pix_tick", int'(a_pix), 0);
    check("rst_b_hsync", int'(b_hs), 1);
    check("rst_b_vsync", int'(b_vs), 1);
    check("rst_b_pix_tick", int'(b_pix), 0);

    // Default instance: line period, hsync width, vsync edge
    clear_a = 1'b1;
    ls_cnt = 0; fs_cnt = 0; ls1 = -1; ls2 = -1; hs_cnt = 0; br_cnt = 0;
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (a_ls) begin
        ls_cnt++;
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
      if (a_fs) fs_cnt++;
      if (ls1 >= 0 && ls2 < 0 && a_pix && !a_hs) hs_cnt++;
      if (a_br) br_cnt++;
      if (k == 1) check("a_pix_tick_edge1", int'(a_pix), 0);
      if (k == 2) begin
        check("a_pix_tick_edge2", int'(a_pix), 1);
        check("a_hsync_first_tick", int'(a_hs), 0);
        check("a_line_start_first_tick", int'(a_ls), 0);
        check("a_frame_start_first_tick", int'(a_fs), 0);
      end
      if (k == 3199) check("a_vsync_line1_end", int'(a_vs), 0);
      if (k == 3200) check("a_vsync_line2_start", int'(a_vs), 1);
    end
    check("a_first_line_start_clk", ls1, 1600);
    check("a_line_period_clk", ls2 - ls1, 1600);
    check("a_line_start_high_cycles", ls_cnt, 2);
    check("a_frame_start_high_cycles", fs_cnt, 0);
    check("a_hsync_low_ticks", hs_cnt, 96);
    check("a_bright_in_vblank", br_cnt, 0);
    clear_a = 1'b0;

    // CLK_DIV=1 / active-high instance: directed position table
    clear_b = 1'b1;
    nb = 0; ls1 = -1; ls2 = -1; hs_cnt = 0; pix_lo = 0;
    for (int i = 0; i < NV; i++) begin
      pos = vecs[i].v * 800 + vecs[i].h;
      while (nb < pos) begin
        @(negedge clk);
        nb++;
        if (b_ls) begin
          if (ls1 < 0) ls1 = nb;
          else if (ls2 < 0) ls2 = nb;
        end
        if (nb >= 800 && nb < 1600 && b_hs) hs_cnt++;
        if (!b_pix) pix_lo++;
      end
      check($sformatf("b%0d_hsync", i), int'(b_hs), vecs[i].hs);
      check($sformatf("b%0d_vsync", i), int'(b_vs), vecs[i].vs);
      check($sformatf("b%0d_bright", i), int'(b_br), vecs[i].br);
      check($sformatf("b%0d_x", i), int'(b_x), vecs[i].x);
      check($sformatf("b%0d_y", i), int'(b_y), vecs[i].y);
      check($sformatf("b%0d_tile_col", i), int'(b_tc), vecs[i].tc);
      check($sformatf("b%0d_tile_row", i), int'(b_tr), vecs[i].tr);
      check($sformatf("b%0d_tile_px", i), int'(b_px), vecs[i].px);
      check($sformatf("b%0d_tile_py", i), int'(b_py), vecs[i].py);
      check($sformatf("b%0d_fetch_valid", i), int'(b_fv), vecs[i].fv);
      check($sformatf("b%0d_fetch_addr", i), int'(b_fa), vecs[i].fa);
      check($sformatf("b%0d_line_start", i), int'(b_ls), vecs[i].ls);
      check($sformatf("b%0d_frame_start", i), int'(b_fs), 0);
    end
    check("b_first_line_start_clk", ls1, 800);
    check("b_line_period_clk", ls2 - ls1, 800);
    check("b_hsync_high_ticks", hs_cnt, 96);
    check("b_pix_tick_low_cycles", pix_lo, 0);
    clear_b = 1'b0;

    // Small instance: whole-frame model, frame statistics, mid-line reset
    clear_c = 1'b1;
    fs1 = -1; fs2 = -1; br_rise = 0; br_ticks = 0; vs_low = 0; prev_br = 1'b0;
    for (int k = 1; k <= 3320; k++) begin
      @(negedge clk);
      c_model(k);
      if (c_fs) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k >= 1230 && k < 2460) begin
        if (c_br && !prev_br) br_rise++;
        if (c_pix && c_br) br_ticks++;
        if (c_pix && !c_vs) vs_low++;
      end
      prev_br = c_br;
    end
    check("c_first_frame_start_clk", fs1, 1230);
    check("c_frame_period_clk", fs2 - fs1, 1230);
    check("c_bright_lines_per_frame", br_rise, 8);
    check("c_bright_ticks_per_frame", br_ticks, 256);
    check("c_vsync_low_ticks", vs_low, 82);
    check("c_midline_bright", int'(c_br), 1);
    check("c_midline_x", int'(c_x), 13);
    check("c_midline_y", int'(c_y), 5);

    clear_c = 1'b0;
    @(negedge clk);
    check("c_rst_hsync", int'(c_hs), 0);
    check("c_rst_vsync", int'(c_vs), 0);
    check("c_rst_bright", int'(c_br), 0);
    check("c_rst_xy", int'(c_x) + int'(c_y), 0);
    check("c_rst_tiles", int'(c_tc) + int'(c_tr) + int'(c_px) + int'(c_py), 0);
    check("c_rst_fetch_valid", int'(c_fv), 0);
    check("c_rst_fetch_addr", int'(c_fa), 0);
    check("c_rst_pix_tick", int'(c_pix), 0);
    check("c_rst_line_start", int'(c_ls), 0);
    check("c_rst_frame_start", int'(c_fs), 0);

    clear_c = 1'b1;
    fs1 = -1;
    for (int k = 1; k <= 1240; k++) begin
      @(negedge clk);
      c_model(k);
      if (c_fs && fs1 < 0) fs1 = k;
      if (k == 2) begin
        check("c_release_pix_tick", int'(c_pix), 1);
        check("c_release_line_start", int'(c_ls), 0);
        check("c_release_frame_start", int'(c_fs), 0);
      end
    end
    check("c_release_frame_start_clk", fs1, 1230);
    check("c_model_divergent_samples", c_mm, 0);
    if (c_mm > 0) $display("small raster first diverged at clk %0d after its reset release", c_first);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates pixel-clock enable, h/v sync with selectable polarity, a blanking-aware bright signal, and visible-area pixel coordinates.
- Also generates tile (glyph) coordinates, tile address and a lookahead fetch address so glyph/tile memory with registered read latency can be prefetched.
- Sits between the system clock and the bitgen/glyph renderer; one instance per display.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (2 = 25 MHz from 50 MHz); legal 1..16
- H_PULSE, 96, hsync pulse length in pixel ticks
- H_BACK, 48, horizontal back porch, pixel ticks
- H_VID, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, pixel ticks
- V_PULSE, 2, vsync pulse length in lines
- V_BACK, 33, vertical back porch, lines
- V_VID, 480, visible lines
- V_FRONT, 10, vertical front porch, lines
- SYNC_ACTIVE_LOW, 1, 1: sync pulses drive 0; 0: sync pulses drive 1
- TILE_BITS, 4, log2 of tile edge in pixels (16x16 tiles, 40x30 grid)
- FETCH_LEAD, 2, pixel ticks the fetch address leads the displayed pixel; legal 1..H_BACK
- CW, 10, coordinate/counter width

Ports:
- clk, in, 1, system clock
- clear, in, 1, synchronous active-low reset
- pix_tick, out, 1, one-clk pulse marking each pixel tick
- hSync, out, 1, horizontal sync
- vSync, out, 1, vertical sync
- bright, out, 1, current pixel is in the visible area
- x, out, CW, visible column 0..H_VID-1; 0 while blank
- y, out, CW, visible row 0..V_VID-1; 0 while blank
- tile_col, out, CW-TILE_BITS, x >> TILE_BITS
- tile_row, out, CW-TILE_BITS, y >> TILE_BITS
- tile_px, out, TILE_BITS, x within tile (x[TILE_BITS-1:0])
- tile_py, out, TILE_BITS, y within tile
- fetch_addr, out, 12, tile index (tile_row*cols + tile_col) of the pixel FETCH_LEAD ticks ahead
- fetch_valid, out, 1, that lookahead pixel is visible
- line_start, out, 1, high for one pixel tick at h_raw==0
- frame_start, out, 1, high for one pixel tick at h_raw==0 && v_raw==0

Behaviour:
- Derived: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525); H_ACT0 = H_PULSE+H_BACK (144); V_ACT0 = V_PULSE+V_BACK (35); COLS = H_VID >> TILE_BITS.
- Divider: div counts 0..CLK_DIV-1; pix_tick = (div == CLK_DIV-1). With CLK_DIV=1, pix_tick is constantly 1 after reset.
- Raw counters h_raw and v_raw advance only on pix_tick.
  - h_raw wraps H_TOTAL-1 -> 0.
  - v_raw increments in the same tick that h_raw wraps, and wraps V_TOTAL-1 -> 0.
  - No extra cycle of delay (fixes the off-by-one in the old controller).
- Region order, both axes: sync pulse, back porch, active, front porch.
- All outputs are registered and computed from the next-state counters, so they change on the same edge that the counters advance. Zero extra latency relative to h_raw/v_raw.
- hSync is at the active level iff h_raw < H_PULSE; vSync is at the active level iff v_raw < V_PULSE. The active level is 0 if SYNC_ACTIVE_LOW, else 1.
- bright = 1 iff H_ACT0 <= h_raw < H_ACT0+H_VID and V_ACT0 <= v_raw < V_ACT0+V_VID.
  - When bright: x = h_raw-H_ACT0, y = v_raw-V_ACT0.
  - When not bright: x = y = 0, and the tile outputs are 0.
- Lookahead: hf = h_raw+FETCH_LEAD, on the same line with no wrap.
  - fetch_valid = hf in active h range && v_raw in active v range.
  - fetch_addr = ((v_raw-V_ACT0)>>TILE_BITS)*COLS + ((hf-H_ACT0)>>TILE_BITS) when valid, else 0.
  - Implement the multiply as shift/add or as a registered running row base, not a generic multiplier.
- line_start and frame_start are asserted only during the tick's hold period; they are deasserted between ticks when CLK_DIV > 1.
- Reset: when clear==0 at a clk edge, set:
  - div=0, h_raw=0, v_raw=0;
  - hSync and vSync at the active level;
  - bright=0, x=y=0, all tile outputs 0;
  - fetch_valid=0, fetch_addr=0, pix_tick=0, line_start=0, frame_start=0.
- Reset mid-frame takes effect on that edge. The first tick after release produces h_raw=1, with line_start and frame_start low. The next frame_start occurs at the wrap.
- No other mode or state; the counters are the only state besides the output registers.

Decomposition:
- Package vga_pkg holds:
  - default timing constants for 640x480@60;
  - derived H_TOTAL/V_TOTAL/H_ACT0/V_ACT0 functions;
  - the 8-bit RRR_GGG_BB colour constants shared with bitgen.
- Sub-module vga_axis_counter: one counter with PULSE/BACK/VID/FRONT parameters, enable input, and wrap/sync/active outputs. Instantiated twice: h (enable = pix_tick) and v (enable = pix_tick && h wrap).

Test Plan:
- Reset: hold clear=0 for 3 clks -> hSync=0, vSync=0, bright=0, x=y=0, fetch_addr=0, pix_tick=0.
- Line timing (defaults): after release, line_start pulses are 800 pix_ticks (1600 clk) apart; hSync is low for exactly 96 ticks per line.
- Visible window: bright rises at h_raw=144 with x=0, and is last high at h_raw=783 with x=639. Over a full frame: 480 bright lines, first at y=0 (v_raw=35).
- Frame: frame_start pulses every 525*800 ticks; vSync is low for exactly 2 lines (1600 ticks).
- Tile/fetch: when x=16, y=32 -> tile_col=1, tile_row=2, tile_px=0, tile_py=0. Two ticks before that pixel, fetch_valid=1 and fetch_addr=81. At x=638, fetch_valid=0.
- Reset mid-line at v_raw=100, h_raw=500 -> all outputs return to reset values on that edge. Rerun the line-timing test with CLK_DIV=1 and SYNC_ACTIVE_LOW=0: syncs are high during pulses and the line is 800 clk long.
